rc5_key_schedule: RTL and testbench
===================================

# rc5_key_schedule

Parametrised RC5 key-expansion engine for the RC5 datapath. It latches a b-byte secret key, initialises the expanded-key table S with the magic constants P_w/Q_w, then runs the full 3·max(t,c) mixing loop, including the data-dependent rotation of L. S lives in an external single-port synchronous RAM that the encrypt/decrypt rounds read later. The block supports word sizes of 16, 32 and 64 bits, any round count and any key length.

## Interface
Parameters:
- W, 32, word size in bits; only 16, 32 or 64 are legal.
- R, 12, number of rounds.
- B, 16, key length in bytes, range 0..255.
- T, 2·R+2, number of S entries (derived).
- C, max(1, ceil(B/(W/8))), number of L words (derived).
- T_LEN, $clog2(T), S address width (derived).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin expansion; sampled only in IDLE.
- key  in  8·max(B,1)  secret key, byte 0 in bits [7:0]; latched on accepted start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when S is complete.
- s_addr  out  T_LEN  S RAM address.
- s_we  out  1  S RAM write enable.
- s_wdata  out  W  S RAM write data.
- s_rdata  in  W  S RAM read data, valid one cycle after s_addr is presented.

## Operation
- FSM states: IDLE → LOAD → INIT → MIX_RD ↔ MIX_WR → FIN → IDLE.
- **IDLE**:
  - start=1 moves to LOAD.
  - The key is latched into the internal L register array in the same cycle.
- **LOAD**:
  - L[k] = little-endian packing of key bytes k·W/8 .. k·W/8+W/8−1.
  - Missing bytes are zero. For B=0, L[0]=0.
- **INIT** (T cycles):
  - Writes S[i] = P_w + i·Q_w mod 2^W for i = 0..T−1.
  - Constants for W=16: P=B7E1, Q=9E37.
  - Constants for W=32: P=B7E15163, Q=9E3779B9.
  - Constants for W=64: P=B7E151628AED2A6B, Q=9E3779B97F4A7C15.
- **MIX**:
  - Runs N = 3·max(T,C) iterations. A, B, i and j start at 0.
  - MIX_RD: s_addr=i, s_we=0.
  - MIX_WR:
    - A = ROTL(s_rdata+A+B, 3).
    - Write S[i]=A.
    - B = ROTL(L[j]+A+B, (A+B) mod W).
    - L[j] = B.
    - i = (i+1) mod T; j = (j+1) mod C.
  - All additions are mod 2^W. The rotate amount uses the low log2(W) bits of A+B, where A is the newly computed value.
- **FIN**: pulses done for one cycle, then returns to IDLE. A, B and the iteration count are cleared.
- start while busy is ignored. start in the same cycle as FIN is ignored.
- i and j wrap independently. When T is not a multiple of C, the wraps must not synchronise.

## Timing
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE; A, B, i, j, the iteration count and L are 0.
- Latency from the start edge to done=1: 1 (LOAD) + T (INIT) + 2·N (MIX) + 1 cycles.
- For the defaults (T=26, C=4, N=78): 184 cycles.
- s_we is high in every INIT cycle and every MIX_WR cycle, and low otherwise.
- s_addr is 0 whenever s_we is 0, except during MIX_RD.
- rst mid-operation:
  - Returns to IDLE on the next edge.
  - Drops busy and s_we immediately; no done pulse is produced.
  - S RAM contents are then undefined; the consumer must wait for done.

## Configuration
- **RC5_KS_SCRUB_EN defined**:
  - FIN lasts 2 cycles. The first cycle zeroes every L word and A/B; done pulses in the second.
  - Latency is +1 (185 cycles for the defaults).
- **RC5_KS_SCRUB_EN undefined**:
  - FIN is 1 cycle.
  - L keeps the final mixed values until the next start.

## Structure
- Shared package rc5_pkg holds:
  - P/Q constant functions selected by W.
  - A rotl(word, amt) function.
  - The FSM state enum.
  - The C/T derivation functions.
- One sub-module: rc5_rotl (barrel rotate-left, W-parametrised). It is instantiated once for the fixed 3-bit rotate and once for the variable rotate.
- L is a register array inside rc5_key_schedule. S stays external.

## Test plan
- W=32, R=12, start pulse → INIT writes S[0]=B7E15163, S[1]=5618CB1C, S[25]=? per model; done exactly 184 cycles after the start edge.
- W=32, B=16, key all zeros → all 26 S words match the C reference model; also run the same check with key 00 01 .. 0F.
- W=16, R=12, B=8 (C=4) and W=64, R=24, B=5 (C=1) → S matches the model; latencies are 1+26+156+1 and 1+50+300+1 cycles respectively.
- B=0 → L[0]=0, C=1, no X on any output; S matches the model.
- start re-asserted at cycle 50 of a run → ignored, same S and done timing; rst asserted at cycle 100 → busy=0, s_we=0 next cycle, no done; a new start then completes normally.
- With RC5_KS_SCRUB_EN → L words and A/B read 0 at done, latency 185 cycles; without the macro → L holds the final B value.

Source files
------------

// File: rtl/rc5_pkg.sv
// -----------------------------------------------------------------------------
// rc5_pkg
// Shared definitions for the RC5 key-expansion engine:
//   - rc5_state_e : key-schedule FSM state encoding
//   - rc5_p/rc5_q : magic constants P_w / Q_w for W = 16, 32, 64
//   - rc5_t/rc5_c : derived table sizes (S entries, L words)
//   - rotl        : width-generic rotate-left on a 64-bit container
// -----------------------------------------------------------------------------
package rc5_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_INIT   = 3'd2,
        ST_MIX_RD = 3'd3,
        ST_MIX_WR = 3'd4,
        ST_FIN    = 3'd5
    } rc5_state_e;

    // P_w = Odd((e-2)*2^w), right-aligned in a 64-bit container.
    function automatic logic [63:0] rc5_p(input int w);
        case (w)
            16:      return 64'h0000_0000_0000_B7E1;
            64:      return 64'hB7E1_5162_8AED_2A6B;
            default: return 64'h0000_0000_B7E1_5163;
        endcase
    endfunction

    // Q_w = Odd((phi-1)*2^w), right-aligned in a 64-bit container.
    function automatic logic [63:0] rc5_q(input int w);
        case (w)
            16:      return 64'h0000_0000_0000_9E37;
            64:      return 64'h9E37_79B9_7F4A_7C15;
            default: return 64'h0000_0000_9E37_79B9;
        endcase
    endfunction

    // Number of expanded-key words S.
    function automatic int rc5_t(input int r);
        return 2 * r + 2;
    endfunction

    // Number of key words L; a zero-length key still needs one (zero) word.
    function automatic int rc5_c(input int b, input int w);
        if (b == 0) return 1;
        return (b + (w / 8) - 1) / (w / 8);
    endfunction

    // Rotate the low w bits of word left by amt mod w; upper bits return 0.
    function automatic logic [63:0] rotl(input logic [63:0] word, input int unsigned amt,
                                         input int unsigned w);
        logic [63:0]  mask;
        logic [63:0]  x;
        int unsigned  a;
        mask = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        x    = word & mask;
        a    = amt % w;
        if (a == 0) return x;
        return ((x << a) | (x >> (w - a))) & mask;
    endfunction

endpackage

// File: rtl/rc5_rotl.sv
// -----------------------------------------------------------------------------
// rc5_rotl
// Combinational barrel rotate-left, log2(W) stages.
// Ports:
//   word_i  in  W          word to rotate
//   amt_i   in  log2(W)    rotate amount
//   word_o  out W          word_i rotated left by amt_i
// -----------------------------------------------------------------------------
module rc5_rotl #(
    parameter int W = 32
) (
    input  logic [W-1:0]         word_i,
    input  logic [$clog2(W)-1:0] amt_i,
    output logic [W-1:0]         word_o
);

    localparam int AW = $clog2(W);

    logic [W-1:0] stage [AW+1];

    assign stage[0] = word_i;

    // Stage s rotates by 2^s when amount bit s is set.
    for (genvar s = 0; s < AW; s++) begin : g_stage
        assign stage[s+1] = amt_i[s] ? {stage[s][W-1-(1<<s):0], stage[s][W-1 -: (1<<s)]}
                                     : stage[s];
    end

    assign word_o = stage[AW];

endmodule

// File: rtl/rc5_key_schedule.sv
// -----------------------------------------------------------------------------
// rc5_key_schedule
// RC5 key expansion: latches a B-byte key into L, fills the external S RAM with
// P_w + i*Q_w, then runs 3*max(T,C) mixing iterations (read S[i], write the
// new A back, update L[j] with the data-dependent rotate).
//
// Optional build macro: RC5_KS_SCRUB_EN -- FIN takes an extra cycle that zeroes
// L, A and B before done is pulsed.
//
// Ports:
//   clk      in  1          clock, rising edge
//   rst      in  1          synchronous active-high reset
//   start    in  1          begin expansion (only honoured in IDLE)
//   key      in  8*max(B,1) secret key, byte 0 in bits [7:0]
//   busy     out 1          expansion in progress
//   done     out 1          one-cycle pulse, S complete
//   s_addr   out T_LEN      S RAM address
//   s_we     out 1          S RAM write enable
//   s_wdata  out W          S RAM write data
//   s_rdata  in  W          S RAM read data, one cycle after s_addr
//
// Handshake: start is a level sampled on a rising edge while IDLE; busy rises
// on the following cycle and falls in the cycle done pulses. S RAM reads are
// fixed-latency (address in MIX_RD, data consumed in MIX_WR).
// -----------------------------------------------------------------------------
module rc5_key_schedule
    import rc5_pkg::*;
#(
    parameter int W     = 32,
    parameter int R     = 12,
    parameter int B     = 16,
    parameter int T     = rc5_t(R),
    parameter int C     = rc5_c(B, W),
    parameter int T_LEN = $clog2(T)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [8*((B > 0) ? B : 1)-1:0] key,
    output logic                           busy,
    output logic                           done,
    output logic [T_LEN-1:0]               s_addr,
    output logic                           s_we,
    output logic [W-1:0]                   s_wdata,
    input  logic [W-1:0]                   s_rdata
);

    localparam int NB    = W / 8;
    localparam int LW    = $clog2(W);
    localparam int N     = 3 * ((T > C) ? T : C);
    localparam int CNT_W = $clog2(N + 1);
    localparam int J_W   = (C > 1) ? $clog2(C) : 1;

    localparam logic [W-1:0] P_W = W'(rc5_p(W));
    localparam logic [W-1:0] Q_W = W'(rc5_q(W));

    rc5_state_e       state_q;
    logic             busy_q;
    logic             done_q;
    logic [T_LEN-1:0] i_q;
    logic [J_W-1:0]   j_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     l_q [C];
`ifdef RC5_KS_SCRUB_EN
    logic             scrub_q;
`endif

    // Key bytes packed little-endian into C words; bytes past B read as zero.
    logic [C*W-1:0] key_flat;

    for (genvar n = 0; n < C * NB; n++) begin : g_pack
        if (n < B) begin : g_key
            assign key_flat[8*n +: 8] = key[8*n +: 8];
        end else begin : g_zero
            assign key_flat[8*n +: 8] = 8'h00;
        end
    end

    // Mixing datapath: A' = ROTL(S[i]+A+B, 3); B' = ROTL(L[j]+A'+B, A'+B).
    logic [W-1:0] a_sum;
    logic [W-1:0] a_d;
    logic [W-1:0] ab_sum;
    logic [W-1:0] b_sum;
    logic [W-1:0] b_d;

    assign a_sum  = s_rdata + a_q + b_q;
    assign ab_sum = a_d + b_q;
    assign b_sum  = l_q[j_q] + ab_sum;

    rc5_rotl #(.W(W)) u_rotl_a (
        .word_i (a_sum),
        .amt_i  (LW'(3)),
        .word_o (a_d)
    );

    rc5_rotl #(.W(W)) u_rotl_b (
        .word_i (b_sum),
        .amt_i  (ab_sum[LW-1:0]),
        .word_o (b_d)
    );

    // RAM port decode; address parks at 0 when nothing is being accessed.
    always_comb begin
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        case (state_q)
            ST_INIT: begin
                s_we    = 1'b1;
                s_addr  = i_q;
                s_wdata = a_q;
            end
            ST_MIX_RD: begin
                s_addr  = i_q;
            end
            ST_MIX_WR: begin
                s_we    = 1'b1;
                s_addr  = i_q;
                s_wdata = a_d;
            end
            default: ;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            for (int k = 0; k < C; k++) l_q[k] <= '0;
`ifdef RC5_KS_SCRUB_EN
            scrub_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < C; k++) l_q[k] <= key_flat[k*W +: W];
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // A doubles as the P + i*Q accumulator during INIT.
                    a_q     <= P_W;
                    i_q     <= '0;
                    state_q <= ST_INIT;
                end
                ST_INIT: begin
                    if (i_q == T_LEN'(T - 1)) begin
                        i_q     <= '0;
                        a_q     <= '0;
                        state_q <= ST_MIX_RD;
                    end else begin
                        i_q <= i_q + T_LEN'(1);
                        a_q <= a_q + Q_W;
                    end
                end
                ST_MIX_RD: begin
                    state_q <= ST_MIX_WR;
                end
                ST_MIX_WR: begin
                    a_q      <= a_d;
                    b_q      <= b_d;
                    l_q[j_q] <= b_d;
                    // i and j wrap on their own moduli.
                    i_q <= (i_q == T_LEN'(T - 1)) ? '0 : i_q + T_LEN'(1);
                    j_q <= (j_q == J_W'(C - 1))   ? '0 : j_q + J_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_FIN;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= ST_MIX_RD;
                    end
                end
                ST_FIN: begin
                    a_q   <= '0;
                    b_q   <= '0;
                    cnt_q <= '0;
                    i_q   <= '0;
                    j_q   <= '0;
`ifdef RC5_KS_SCRUB_EN
                    if (!scrub_q) begin
                        scrub_q <= 1'b1;
                        for (int k = 0; k < C; k++) l_q[k] <= '0;
                    end else begin
                        scrub_q <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
`else
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_rc5_key_schedule
// Four configurations of rc5_key_schedule, each with its own S RAM, driver
// and done monitor. Expected S/L/latency come from a reference key-schedule
// model written in the plain loop style of the RC5 reference code.
//   cfg0: W=32 R=12 B=16 (zero key, 00..0F key, restart-ignore, mid-run reset)
//   cfg1: W=16 R=12 B=8
//   cfg2: W=64 R=24 B=5
//   cfg3: W=32 R=12 B=0
// -----------------------------------------------------------------------------
module tb_rc5_key_schedule;

    logic clk = 1'b0;
    logic rst_glob = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   blocks_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cfg_w(input int g);
        case (g)
            1:       return 16;
            2:       return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_r(input int g);
        return (g == 2) ? 24 : 12;
    endfunction

    function automatic int cfg_b(input int g);
        case (g)
            0:       return 16;
            1:       return 8;
            2:       return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] p_of(input int w);
        case (w)
            16:      return 64'hB7E1;
            64:      return 64'hB7E151628AED2A6B;
            default: return 64'hB7E15163;
        endcase
    endfunction

    function automatic logic [63:0] q_of(input int w);
        case (w)
            16:      return 64'h9E37;
            64:      return 64'h9E3779B97F4A7C15;
            default: return 64'h9E3779B9;
        endcase
    endfunction

    function automatic logic [63:0] rotl_m(input logic [63:0] x, input int unsigned amt, input int w);
        logic [63:0] m;
        int unsigned a;
        m = mask_of(w);
        a = amt % w;
        x = x & m;
        if (a == 0) return x;
        return ((x << a) | (x >> (w - a))) & m;
    endfunction

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cfg%0d actual=%h expected=%h", nm, g, act, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int GW   = cfg_w(g);
        localparam int GR   = cfg_r(g);
        localparam int GB   = cfg_b(g);
        localparam int GT   = 2 * GR + 2;
        localparam int GC   = (GB == 0) ? 1 : (GB + GW / 8 - 1) / (GW / 8);
        localparam int GTL  = $clog2(GT);
        localparam int GKW  = 8 * ((GB > 0) ? GB : 1);
        localparam int GN   = 3 * ((GT > GC) ? GT : GC);
`ifdef RC5_KS_SCRUB_EN
        localparam int GLAT = 1 + GT + 2 * GN + 2;
`else
        localparam int GLAT = 1 + GT + 2 * GN + 1;
`endif

        logic           rst_loc = 1'b0;
        logic           rst_g;
        logic           start = 1'b0;
        logic [GKW-1:0] key_r = '0;
        logic           busy;
        logic           done;
        logic [GTL-1:0] s_addr;
        logic           s_we;
        logic [GW-1:0]  s_wdata;
        logic [GW-1:0]  s_rdata;
        logic [GW-1:0]  mem [GT];
        int             done_cnt = 0;

        logic [63:0] exp_ia_q [$];
        logic [63:0] exp_id_q [$];
        logic [63:0] exp_s_q [$];
        logic [63:0] exp_l_q [$];
        int          exp_lat_q [$];
        int          exp_cyc_q [$];
        logic [63:0] model_s [GT];
        logic [63:0] model_l [GC];

        assign rst_g = rst_glob | rst_loc;

        rc5_key_schedule #(.W(GW), .R(GR), .B(GB)) u_dut (
            .clk     (clk),
            .rst     (rst_g),
            .start   (start),
            .key     (key_r),
            .busy    (busy),
            .done    (done),
            .s_addr  (s_addr),
            .s_we    (s_we),
            .s_wdata (s_wdata),
            .s_rdata (s_rdata)
        );

        // Single-port synchronous S RAM.
        always @(posedge clk) begin
            if (s_we) mem[s_addr] <= s_wdata;
            s_rdata <= mem[s_addr];
        end

        // Reference key schedule (byte-wise L build, then 3*max(t,c) mixing).
        function automatic void build_model(input logic [GKW-1:0] k);
            logic [63:0] m;
            logic [63:0] a;
            logic [63:0] b;
            logic [63:0] ll [GC];
            int u;
            int ii;
            int jj;
            m = mask_of(GW);
            u = GW / 8;
            for (int c = 0; c < GC; c++) ll[c] = 64'd0;
            for (int x = GB - 1; x >= 0; x--)
                ll[x / u] = ((ll[x / u] << 8) + {56'd0, k[8*x +: 8]}) & m;
            model_s[0] = p_of(GW);
            for (int x = 1; x < GT; x++) model_s[x] = (model_s[x-1] + q_of(GW)) & m;
            a = 64'd0; b = 64'd0; ii = 0; jj = 0;
            for (int n = 0; n < GN; n++) begin
                a = rotl_m(model_s[ii] + a + b, 3, GW);
                model_s[ii] = a;
                b = rotl_m(ll[jj] + a + b, int'((a + b) & 64'h3F), GW);
                ll[jj] = b;
                ii = (ii + 1) % GT;
                jj = (jj + 1) % GC;
            end
            for (int c = 0; c < GC; c++) model_l[c] = ll[c];
        endfunction

        function automatic logic [GKW-1:0] make_key(input int mode);
            logic [GKW-1:0] k;
            k = '0;
            for (int x = 0; x < GKW / 8; x++) begin
                case (mode)
                    1:       k[8*x +: 8] = 8'(x);
                    2:       k[8*x +: 8] = 8'(x * 29) ^ 8'h5A;
                    default: k[8*x +: 8] = 8'h00;
                endcase
            end
            return k;
        endfunction

        task automatic flush();
            exp_ia_q.delete(); exp_id_q.delete(); exp_s_q.delete();
            exp_l_q.delete(); exp_lat_q.delete(); exp_cyc_q.delete();
        endtask

        task automatic issue(input logic [GKW-1:0] k);
            logic [63:0] v;
            @(negedge clk);
            build_model(k);
            v = p_of(GW);
            for (int x = 0; x < GT; x++) begin
                exp_ia_q.push_back(64'(x));
                exp_id_q.push_back(v);
                v = (v + q_of(GW)) & mask_of(GW);
            end
            for (int x = 0; x < GT; x++) exp_s_q.push_back(model_s[x]);
`ifdef RC5_KS_SCRUB_EN
            for (int c = 0; c < GC; c++) exp_l_q.push_back(64'd0);
`else
            for (int c = 0; c < GC; c++) exp_l_q.push_back(model_l[c]);
`endif
            exp_lat_q.push_back(GLAT);
            exp_cyc_q.push_back(cyc + 1);
            key_r = k;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        endtask

        task automatic wait_done(input int n0);
            for (int t = 0; t < GLAT + 20 && done_cnt == n0; t++) @(negedge clk);
            checks++;
            if (done_cnt == n0) begin
                failures++;
                $display("FAIL done_timeout cfg%0d actual=no_done expected=done", g);
                flush();
            end
        endtask

        task automatic run(input int mode);
            int n0;
            n0 = done_cnt;
            issue(make_key(mode));
            wait_done(n0);
        endtask

        task automatic reset_checks();
            repeat (2) @(negedge clk);
            chk("rst_busy", g, 64'(busy), 64'd0);
            chk("rst_done", g, 64'(done), 64'd0);
            chk("rst_we", g, 64'(s_we), 64'd0);
            chk("rst_addr", g, 64'(s_addr), 64'd0);
            chk("rst_wdata", g, 64'(s_wdata), 64'd0);
            while (rst_g) @(negedge clk);
        endtask

        // Monitor: INIT writes and the done-time snapshot against the queues.
        always @(negedge clk) begin
            if (!rst_g) begin
                if (s_we && exp_ia_q.size() > 0) begin
                    chk("init_addr", g, 64'(s_addr), exp_ia_q.pop_front());
                    chk("init_data", g, 64'(s_wdata), exp_id_q.pop_front());
                end
                if (done) begin
                    if (exp_lat_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done cfg%0d actual=1 expected=0", g);
                    end else begin
                        chk("latency", g, 64'(cyc - exp_cyc_q.pop_front()), 64'(exp_lat_q.pop_front()));
                        for (int x = 0; x < GT; x++)
                            chk($sformatf("s_word[%0d]", x), g, 64'(mem[x]), exp_s_q.pop_front());
                        for (int c = 0; c < GC; c++)
                            chk($sformatf("l_word[%0d]", c), g, 64'(u_dut.l_q[c]), exp_l_q.pop_front());
                        chk("a_clear", g, 64'(u_dut.a_q), 64'd0);
                        chk("b_clear", g, 64'(u_dut.b_q), 64'd0);
                        chk("busy_at_done", g, 64'(busy), 64'd0);
                        chk("no_x", g, 64'($isunknown({busy, s_we, s_addr, s_wdata})), 64'd0);
                    end
                    done_cnt++;
                end
            end
        end

        if (g == 0) begin : g_drv_main
            initial begin
                logic [63:0] ea;
                logic [63:0] eb;
                logic [63:0] tmp;
                int n0;
                reset_checks();
                run(0);
                // Encrypt an all-zero block with the expanded table.
                ea = 64'(mem[0]);
                eb = 64'(mem[1]);
                for (int r = 1; r <= 12; r++) begin
                    tmp = rotl_m(ea ^ eb, int'(eb[4:0]), 32);
                    ea  = (tmp + 64'(mem[2*r])) & 64'hFFFF_FFFF;
                    tmp = rotl_m(eb ^ ea, int'(ea[4:0]), 32);
                    eb  = (tmp + 64'(mem[2*r+1])) & 64'hFFFF_FFFF;
                end
                chk("ct_a", g, ea, 64'hEEDBA521);
                chk("ct_b", g, eb, 64'h6D8F4B15);
                run(1);
                // A second start mid-run must not disturb the active expansion.
                n0 = done_cnt;
                issue(make_key(2));
                repeat (48) @(negedge clk);
                key_r = make_key(1);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                wait_done(n0);
                // Reset at cycle ~100 of a run: busy/s_we drop, no done afterwards.
                issue(make_key(1));
                repeat (99) @(negedge clk);
                rst_loc = 1'b1;
                @(negedge clk);
                chk("abort_busy", g, 64'(busy), 64'd0);
                chk("abort_we", g, 64'(s_we), 64'd0);
                chk("abort_done", g, 64'(done), 64'd0);
                flush();
                rst_loc = 1'b0;
                repeat (300) @(negedge clk);
                run(0);
                blocks_done++;
            end
        end else begin : g_drv_simple
            initial begin
                reset_checks();
                run(2);
                run(1);
                blocks_done++;
            end
        end
    end

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_glob = 1'b0;
        for (int t = 0; t < 20000 && blocks_done < 4; t++) @(negedge clk);
        checks++;
        if (blocks_done < 4) begin
            failures++;
            $display("FAIL global_timeout actual=%0d expected=4", blocks_done);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
